// File: rtl/sram_write_port_ctrl.sv
// Write-port controller for a 2R1W SRAM: clears every entry after reset or on request,
// then arbitrates a high-priority and a low-priority write source onto one registered port.
module sram_write_port_ctrl #(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    SIZE         = 1024,
   parameter int                    ADDR_WIDTH   = $clog2(SIZE),
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0,
   parameter int                    STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear_req,
   output logic                  init_done,
   input  logic                  wp0_valid,
   output logic                  wp0_ready,
   input  logic [ADDR_WIDTH-1:0] wp0_addr,
   input  logic [DATA_WIDTH-1:0] wp0_data,
   input  logic                  wp1_valid,
   output logic                  wp1_ready,
   input  logic [ADDR_WIDTH-1:0] wp1_addr,
   input  logic [DATA_WIDTH-1:0] wp1_data,
   output logic                  write_en,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic [DATA_WIDTH-1:0] write_data
);

   typedef enum logic {INIT, RUN} state_e;

   localparam int                    STARVE_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(SIZE - 1);
   localparam logic [STARVE_W-1:0]   STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
   logic [STARVE_W-1:0]   starve_q, starve_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  force1, xfer0, xfer1;

   always_comb begin
      state_d   = state_q;
      sweep_d   = sweep_q;
      starve_d  = starve_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;
      force1    = 1'b0;
      wp0_ready = 1'b0;
      wp1_ready = 1'b0;

      case (state_q)
         INIT: begin
            we_d   = 1'b1;
            addr_d = sweep_q;
            data_d = CLEAR_VALUE;
            // Wrap explicitly so a non-power-of-2 SIZE never walks past the last entry
            if (sweep_q == LAST_ADDR) begin
               sweep_d = '0;
               state_d = RUN;
            end else begin
               sweep_d = sweep_q + 1'b1;
            end
         end
         RUN: begin
            force1    = wp1_valid && (starve_q == STARVE_MAX);
            wp0_ready = !force1;
            wp1_ready = force1 || !wp0_valid;
            if (clear_req) begin
               state_d = INIT;
               sweep_d = '0;
            end
         end
         default: state_d = INIT;
      endcase

      xfer0 = wp0_valid && wp0_ready;
      xfer1 = wp1_valid && wp1_ready;

      if (xfer0) begin
         we_d   = 1'b1;
         addr_d = wp0_addr;
         data_d = wp0_data;
      end else if (xfer1) begin
         we_d   = 1'b1;
         addr_d = wp1_addr;
         data_d = wp1_data;
      end

      if (xfer1 || !wp1_valid) begin
         starve_d = '0;
      end else if (starve_q != STARVE_MAX) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= INIT;
         sweep_q  <= '0;
         starve_q <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         sweep_q  <= sweep_d;
         starve_q <= starve_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end

   assign init_done  = (state_q == RUN);
   assign write_en   = we_q;
   assign write_addr = addr_q;
   assign write_data = data_q;

endmodule
